// File: rtl/gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_unit_arbiter
// Purpose  : Round-robin arbiter that shares one WIDTH-bit basic-gate unit
//            (NOT/AND/OR/XOR/NOR/NAND) among N requesters. The result of
//            each accepted request is held in a one-deep registered
//            response slot.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req_valid/req_ready - per-requester handshake (ready is one-hot)
//            req_op/req_a/req_b  - packed per-requester opcode and operands
//            rsp_valid/rsp_ready - response slot handshake
//            rsp_id/rsp_y/rsp_err- response requester index, result, error
//            txn_cnt             - wrapping count of accepted requests
// Revision : 1.0 - initial release
// ============================================================================
module gate_unit_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [3*N-1:0]       req_op,
  input  logic [WIDTH*N-1:0]   req_a,
  input  logic [WIDTH*N-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [WIDTH-1:0]     rsp_y,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     txn_cnt
);

  localparam logic [ID_W:0]   c_n        = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] c_last_idx = ID_W'(N-1);

  localparam logic [2:0] c_op_not  = 3'd0;
  localparam logic [2:0] c_op_and  = 3'd1;
  localparam logic [2:0] c_op_or   = 3'd2;
  localparam logic [2:0] c_op_xor  = 3'd3;
  localparam logic [2:0] c_op_nor  = 3'd4;
  localparam logic [2:0] c_op_nand = 3'd5;

  logic [ID_W-1:0]  r_ptr;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_txn_cnt;

  logic             w_slot_free;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic             w_found;
  logic [ID_W-1:0]  w_off;
  logic [ID_W:0]    w_sum;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_accept;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // Rotate the request vector so the pointer position lands at bit 0; the
  // first set bit of the rotated vector is then the round-robin winner.
  assign w_dbl = {req_valid, req_valid};
  assign w_rot = N'(w_dbl >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = ID_W'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute index, modulo N.
  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= c_n) begin
      w_sum = w_sum - c_n;
    end
    w_gnt_idx = w_sum[ID_W-1:0];
  end

  // Nothing is accepted while reset is held, even if requests are pending.
  assign w_accept = w_slot_free && w_found && !rst;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ready[i] = w_accept && (w_gnt_idx == ID_W'(i));
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_op = req_op[3*i +: 3];
        w_a  = req_a[WIDTH*i +: WIDTH];
        w_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Shared gate datapath; opcodes 6 and 7 yield zero with the error flag.
  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (w_op)
      c_op_not:  w_y = ~w_a;
      c_op_and:  w_y = w_a & w_b;
      c_op_or:   w_y = w_a | w_b;
      c_op_xor:  w_y = w_a ^ w_b;
      c_op_nor:  w_y = ~(w_a | w_b);
      c_op_nand: w_y = ~(w_a & w_b);
      default:   w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_rsp_err   <= 1'b0;
      r_txn_cnt   <= '0;
    end else if (w_accept) begin
      // A new accept overwrites the slot even if it is draining this cycle.
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_y     <= w_y;
      r_rsp_err   <= w_err;
      r_txn_cnt   <= r_txn_cnt + 1'b1;
      r_ptr       <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
    end else if (rsp_ready) begin
      // Drain only clears valid; payload keeps its last value.
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_err   = r_rsp_err;
  assign txn_cnt   = r_txn_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_unit_arbiter
// Purpose  : Directed self-checking bench for gate_unit_arbiter. A second
//            instance with a 4-bit counter shares the stimulus so counter
//            wrap can be observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_unit_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [3*N-1:0]     req_op;
  logic [WIDTH*N-1:0] req_a;
  logic [WIDTH*N-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [WIDTH-1:0]   rsp_y;
  logic               rsp_err;
  logic [CNT_W-1:0]   txn_cnt;

  logic [N-1:0]       req_ready4;
  logic               rsp_valid4;
  logic [ID_W-1:0]    rsp_id4;
  logic [WIDTH-1:0]   rsp_y4;
  logic               rsp_err4;
  logic [3:0]         txn_cnt4;

  int n_checks;
  int n_fails;

  gate_unit_arbiter #(.N(N), .WIDTH(WIDTH), .ID_W(ID_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .txn_cnt(txn_cnt)
  );

  gate_unit_arbiter #(.N(N), .WIDTH(WIDTH), .ID_W(ID_W), .CNT_W(4)) u_dut_cnt4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id4), .rsp_y(rsp_y4), .rsp_err(rsp_err4),
    .txn_cnt(txn_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] sweep_exp [6];

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    sweep_exp = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'h50, 8'hFA};

    // Reset state, with requests pending to show ready is suppressed.
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_y", 32'(rsp_y), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_err", 32'(rsp_err), 32'h0);
    check("rst_cnt", 32'(txn_cnt), 32'h0);
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);

    // Op sweep on requester 2.
    for (int op = 0; op < 6; op++) begin
      set_req(2, 3'(op), 8'hA5, 8'h0F);
      req_valid = 4'b0100;
      #1;
      check("sweep_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      check("sweep_valid", 32'(rsp_valid), 32'h1);
      check("sweep_y", 32'(rsp_y), 32'(sweep_exp[op]));
      check("sweep_id", 32'(rsp_id), 32'h2);
      check("sweep_err", 32'(rsp_err), 32'h0);
    end
    req_valid = '0;
    check("sweep_cnt", 32'(txn_cnt), 32'd6);
    @(negedge clk);
    // Drain with no new accept: valid drops, payload is kept.
    check("drain_valid", 32'(rsp_valid), 32'h0);
    check("drain_y_kept", 32'(rsp_y), 32'hFA);
    check("drain_id_kept", 32'(rsp_id), 32'h2);

    // Fairness from reset, all requesters active.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'hFF, 8'(8'h10 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      @(negedge clk);
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_y", 32'(rsp_y), 32'(8'h10 + (k % 4)));
    end
    req_valid = '0;

    // Backpressure.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 3'd3, 8'h3C, 8'hFF);
    set_req(1, 3'd2, 8'h10, 8'h01);
    req_valid = 4'b0011;
    #1;
    check("bp_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("bp_valid0", 32'(rsp_valid), 32'h1);
    check("bp_id0", 32'(rsp_id), 32'h0);
    check("bp_y0", 32'(rsp_y), 32'hC3);
    req_valid = 4'b0010;
    #1;
    check("bp_blocked", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("bp_hold_valid", 32'(rsp_valid), 32'h1);
    check("bp_hold_id", 32'(rsp_id), 32'h0);
    check("bp_hold_y", 32'(rsp_y), 32'hC3);
    check("bp_hold_cnt", 32'(txn_cnt), 32'd1);
    rsp_ready = 1'b1;
    #1;
    check("bp_ready1", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("bp_valid1", 32'(rsp_valid), 32'h1);
    check("bp_id1", 32'(rsp_id), 32'h1);
    check("bp_y1", 32'(rsp_y), 32'h11);
    req_valid = '0;

    // Illegal opcode, then a legal one clears the error.
    set_req(3, 3'd6, 8'hFF, 8'hFF);
    req_valid = 4'b1000;
    @(negedge clk);
    check("ill_y", 32'(rsp_y), 32'h0);
    check("ill_err", 32'(rsp_err), 32'h1);
    check("ill_id", 32'(rsp_id), 32'h3);
    check("ill_cnt", 32'(txn_cnt), 32'd3);
    set_req(3, 3'd1, 8'hF0, 8'h3C);
    @(negedge clk);
    check("legal_y", 32'(rsp_y), 32'h30);
    check("legal_err", 32'(rsp_err), 32'h0);
    check("legal_cnt", 32'(txn_cnt), 32'd4);
    set_req(3, 3'd7, 8'h12, 8'h34);
    @(negedge clk);
    check("ill7_err", 32'(rsp_err), 32'h1);
    check("ill7_y", 32'(rsp_y), 32'h0);
    req_valid = '0;

    // Asynchronous reset mid-operation with ptr=2 and a held response.
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 3'd1, 8'hFF, 8'h5A);
    req_valid = 4'b0010;
    @(negedge clk);
    check("mid_valid_pre", 32'(rsp_valid), 32'h1);
    check("mid_y_pre", 32'(rsp_y), 32'h5A);
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(rsp_valid), 32'h0);
    check("mid_y", 32'(rsp_y), 32'h0);
    check("mid_cnt", 32'(txn_cnt), 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 3'd2, 8'h00, 8'(i));
    req_valid = 4'b1111;
    #1;
    check("mid_first_gnt", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("mid_first_id", 32'(rsp_id), 32'h0);
    req_valid = '0;

    // Counter wrap on the 4-bit counter instance.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15) check("wrap_cnt15", 32'(txn_cnt4), 32'd15);
      if (k == 16) check("wrap_cnt16", 32'(txn_cnt4), 32'd0);
      if (k == 17) check("wrap_cnt17", 32'(txn_cnt4), 32'd1);
    end
    req_valid = '0;
    check("wide_cnt17", 32'(txn_cnt), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
